// File: rtl/div_sgn_seq.sv
// div_sgn_seq: iterative radix-2 signed divider.
// Restoring division on operand magnitudes, one quotient bit per cycle,
// followed by a single sign-correction cycle. Quotient truncates toward
// zero and the remainder takes the sign of the dividend. Divide by zero
// yields Q = -1, R = X with dbz_o set.
// Optional build macro DIV_SGN_EARLY_OUT_EN: a divide by zero skips the
// iterations and presents its result in the cycle after the accept.
module div_sgn_seq #(
   parameter int width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [width-1:0] X,
   input  logic [width-1:0] Y,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [width-1:0] Q,
   output logic [width-1:0] R,
   output logic             dbz_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);

   // Counter must hold the value width itself without wrapping.
   localparam int CW = $clog2(width) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t           state, state_nxt;
   logic             sx, sy, dbz;
   logic [width-1:0] xr;        // original dividend, returned as R on divide by zero
   logic [width-1:0] ay;        // divisor magnitude
   logic [width-1:0] dvd;       // dividend magnitude shifting out, quotient bits shifting in
   logic [width:0]   rem;       // partial remainder
   logic [CW-1:0]    cnt;
   logic [width+1:0] rem_sh;
   logic [width+1:0] trial;
   logic             trial_neg;

   // Two's-complement negation at word width.
   function automatic logic [width-1:0] neg(input logic [width-1:0] v);
      return (~v) + width'(1);
   endfunction

   // Magnitude of a signed word; -2^(width-1) maps to 2^(width-1) unsigned.
   function automatic logic [width-1:0] mag(input logic signed [width-1:0] v);
      return v[width-1] ? neg(v) : v;
   endfunction

   // Trial subtraction: shift next dividend bit into the remainder, subtract |Y|.
   assign rem_sh    = {rem, dvd[width-1]};
   assign trial     = rem_sh - {2'b00, ay};
   assign trial_neg = trial[width+1];

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid_i) begin
`ifdef DIV_SGN_EARLY_OUT_EN
               if (Y == '0) state_nxt = DONE;
               else         state_nxt = CALC;
`else
               state_nxt = CALC;
`endif
            end
         end
         CALC:    if (cnt == CW'(1)) state_nxt = FIXUP;
         FIXUP:   state_nxt = DONE;
         DONE:    if (out_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from the registered state.
   always_comb begin
      in_ready_o  = (state == IDLE);
      out_valid_o = (state == DONE);
   end

   // Datapath: operand capture, restoring iterations, sign fixup.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sx    <= 1'b0;
         sy    <= 1'b0;
         dbz   <= 1'b0;
         xr    <= '0;
         ay    <= '0;
         dvd   <= '0;
         rem   <= '0;
         cnt   <= '0;
         Q     <= '0;
         R     <= '0;
         dbz_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid_i) begin
                  sx  <= X[width-1];
                  sy  <= Y[width-1];
                  xr  <= X;
                  dvd <= mag($signed(X));
                  ay  <= mag($signed(Y));
                  rem <= '0;
                  cnt <= CW'(width);
                  dbz <= (Y == '0);
`ifdef DIV_SGN_EARLY_OUT_EN
                  if (Y == '0) begin
                     Q     <= '1;
                     R     <= X;
                     dbz_o <= 1'b1;
                  end
`endif
               end
            end
            CALC: begin
               rem <= trial_neg ? rem_sh[width:0] : trial[width:0];
               dvd <= {dvd[width-2:0], ~trial_neg};
               cnt <= cnt - CW'(1);
            end
            FIXUP: begin
               if (dbz) begin
                  Q     <= '1;
                  R     <= xr;
                  dbz_o <= 1'b1;
               end else begin
                  Q     <= (sx ^ sy) ? neg(dvd) : dvd;
                  R     <= sx ? neg(rem[width-1:0]) : rem[width-1:0];
                  dbz_o <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sgn_seq.sv
// Testbench for div_sgn_seq: directed corner cases, backpressure, reset
// mid-operation and randomized operands against an arithmetic reference.
module tb_div_sgn_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_ni = 1'b0;
   logic [W-1:0] x = '0;
   logic [W-1:0] y = '0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic [W-1:0] q;
   logic [W-1:0] r;
   logic         dbz;
   logic         out_valid;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div_sgn_seq #(.width(W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .X           (x),
      .Y           (y),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .Q           (q),
      .R           (r),
      .dbz_o       (dbz),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain signed arithmetic, truncating division.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] eq, output logic [W-1:0] er,
                                 output logic ed);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
         eq = '1;
         er = a;
         ed = 1'b1;
      end else begin
         eq = W'(sa / sb);
         er = W'(sa % sb);
         ed = 1'b0;
      end
   endfunction

   // One full transaction; called at a sample point (#1 after a rising edge).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int bp);
      logic [W-1:0] eq, er;
      logic         ed;
      int           cyc, exp_cyc;
      model(a, b, eq, er, ed);
      exp_cyc = W + 2;
`ifdef DIV_SGN_EARLY_OUT_EN
      if (b == '0) exp_cyc = 1;
`endif
      cyc = 0;
      while (!in_ready && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("in_ready_idle", in_ready, 1);
      x = a; y = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x = W'($urandom); y = W'($urandom);
      check("in_ready_busy", in_ready, 0);
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", cyc, exp_cyc);
      check("q", q, eq);
      check("r", r, er);
      check("dbz", dbz, ed);
      // Backpressure: result must hold, new operands are ignored.
      for (int i = 0; i < bp; i++) begin
         in_valid = 1'b1; x = W'($urandom); y = W'($urandom);
         @(posedge clk); #1;
         check("bp_valid", out_valid, 1);
         check("bp_ready", in_ready, 0);
         check("bp_q", q, eq);
         check("bp_r", r, er);
      end
      // Handshake with in_valid also high: no accept on this edge.
      in_valid = 1'b1; x = W'($urandom); y = W'($urandom);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      check("hs_valid_drop", out_valid, 0);
      check("hs_ready_rise", in_ready, 1);
      check("hs_q_hold", q, eq);
      check("hs_r_hold", r, er);
   endtask

   initial begin
      logic [W-1:0] a, b;
      // Reset values.
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_q", q, 0);
      check("rst_r", r, 0);
      check("rst_dbz", dbz, 0);
      @(posedge clk); #2 rst_ni = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      run_op(8'h07, 8'hFE, 0);
      run_op(8'hF9, 8'h02, 1);
      run_op(8'hF8, 8'h04, 0);
      run_op(8'h80, 8'hFF, 0);
      run_op(8'h80, 8'h01, 2);
      run_op(8'h05, 8'h00, 0);
      run_op(8'h7F, 8'h80, 5);
      run_op(8'h80, 8'h80, 0);

      // Reset during CALC iteration 4.
      run_op(8'h07, 8'hFE, 0);
      x = 8'd100; y = 8'hF9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_ni = 1'b0;
      #1;
      check("arst_in_ready", in_ready, 1);
      check("arst_out_valid", out_valid, 0);
      check("arst_q", q, 0);
      check("arst_r", r, 0);
      check("arst_dbz", dbz, 0);
      @(posedge clk); #2 rst_ni = 1'b1;
      @(posedge clk); #1;
      run_op(8'd100, 8'hF9, 0);

      // Randomized operands with biased corners.
      for (int i = 0; i < 150; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         case ($urandom_range(0, 7))
            0: b = 8'h00;
            1: b = 8'hFF;
            2: b = 8'h01;
            3: a = 8'h80;
            default: ;
         endcase
         run_op(a, b, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/div_sgn_seq.md
# div_sgn_seq

Iterative signed divider (radix-2, restoring on magnitudes), the inverse of the team's signed Baugh-Wooley multiplier in the arithmetic library. It computes truncating two's-complement quotient and remainder, one quotient bit per cycle, behind valid/ready handshakes on both sides. It is intended to share a datapath slot with the multiplier in iterative MUL/DIV units where area matters more than latency.

## Interface
- `width`, default 8: word width of dividend, divisor, quotient and remainder; legal range is 2 to 64.
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_ni`, in, 1: reset, asynchronous and active-low.
- `X`, in, `width`: dividend, signed.
- `Y`, in, `width`: divisor, signed.
- `in_valid_i`, in, 1: operands valid.
- `in_ready_o`, out, 1: divider can accept operands.
- `Q`, out, `width`: quotient, signed.
- `R`, out, `width`: remainder, signed.
- `dbz_o`, out, 1: result came from a divide by zero; qualified by `out_valid_o`.
- `out_valid_o`, out, 1: `Q`, `R` and `dbz_o` are valid.
- `out_ready_i`, in, 1: consumer takes the result.

## Operation
- FSM states:
  - **IDLE**: waiting for operands.
  - **CALC**: one quotient bit per cycle.
  - **FIXUP**: sign and special-case correction.
  - **DONE**: result held for the consumer.
- Transitions:
  - IDLE to CALC on `in_valid_i`.
  - CALC to FIXUP after `width` iterations.
  - FIXUP to DONE unconditionally.
  - DONE to IDLE on `out_ready_i`.
- Accept (`in_valid_i && in_ready_o` at an edge):
  - Register `sX = X[msb]` and `sY = Y[msb]`.
  - Register magnitudes |X| and |Y| as `width`-bit unsigned values. |−2^(width−1)| = 2^(width−1) is representable unsigned.
  - Clear the partial remainder (`width+1` bits).
  - Load the iteration counter with `width`. The counter is `$clog2(width)+1` bits and must not wrap.
  - Latch `dbz = (Y == 0)`.
- CALC step, repeated until the counter reaches 0:
  - Shift the MSB of the dividend register into the partial remainder.
  - Compute trial = rem − |Y|.
  - If trial ≥ 0: rem ← trial and shift quotient bit 1. Otherwise shift quotient bit 0.
  - Decrement the counter.
- FIXUP:
  - Q = (sX ^ sY) ? −|Q| : |Q|.
  - R = sX ? −rem : rem.
  - Quotient truncates toward zero; R takes the sign of X, or is 0.
- Divide by zero (dbz): overrides FIXUP. Q = all ones (−1), R = X, `dbz_o` = 1.
- Overflow (X = −2^(width−1), Y = −1): no special handling; the arithmetic yields Q = −2^(width−1), R = 0, `dbz_o` = 0.
- Operands are sampled only at accept; `X` and `Y` may change freely afterwards.

## Timing
- Reset values:
  - Outputs: `in_ready_o` = 1, `out_valid_o` = 0, `Q` = 0, `R` = 0, `dbz_o` = 0.
  - Internal: FSM = IDLE, counter and datapath registers = 0.
- `in_ready_o` = 1 only in IDLE (registered state decode); it is 0 in CALC, FIXUP and DONE.
- Latency (baseline): accept at edge 0, then CALC edges 1 to `width`, FIXUP at edge `width`+1. `out_valid_o` rises after edge `width`+1 and is visible in cycle `width`+2.
- `out_valid_o`, `Q`, `R` and `dbz_o` stay stable while `out_valid_o && !out_ready_i`. Arbitrary backpressure must be tolerated.
- On the result handshake edge, the FSM goes to IDLE; `out_valid_o` drops and `in_ready_o` rises the next cycle. No accept occurs on the same edge as the output handshake. Minimum issue interval is `width`+3 cycles.
- `Q`, `R` and `dbz_o` keep their last values after the handshake, until the next FIXUP.
- `in_valid_i` asserted while busy is ignored and not queued.
- Reset asserted in any state: immediate asynchronous return to reset values; the in-flight operation is discarded with no partial result.

## Configuration
- `DIV_SGN_EARLY_OUT_EN` defined:
  - On an accept with Y == 0, the FSM goes IDLE to DONE directly, loading Q = −1, R = X, `dbz_o` = 1.
  - `out_valid_o` is visible in cycle 1.
- Not defined: divide by zero runs the full CALC and FIXUP path, taking `width`+2 cycles, with the identical result (override applied in FIXUP).
- The non-dbz path is cycle-identical in both builds.

## Test plan
- `width`=8, X=7, Y=−2 (0xFE) → Q=0xFD (−3), R=0x01, dbz=0; `out_valid_o` exactly 10 cycles after the accept edge.
- X=−7 (0xF9), Y=2 → Q=0xFD (−3), R=0xFF (−1); X=−8, Y=4 → Q=0xFE, R=0x00.
- X=0x80, Y=0xFF → Q=0x80, R=0x00, dbz=0; X=0x80, Y=0x01 → Q=0x80, R=0x00.
- X=0x05, Y=0 → Q=0xFF, R=0x05, dbz=1. Latency is 1 cycle with `DIV_SGN_EARLY_OUT_EN` and 10 cycles without.
- Backpressure:
  - Hold `out_ready_i`=0 for 5 cycles in DONE → Q/R stable, `in_ready_o`=0, and a new `in_valid_i` is ignored.
  - Then a handshake occurs, and the next operands are accepted exactly 1 cycle later.
- Reset: pull `rst_ni` low at CALC iteration 4 → outputs return to reset values asynchronously. After release, 100/−7 → Q=0xF2 (−14), R=0x02.
